// File: rtl/gpio_stream_tx_if.sv
// gpio_stream_tx_if: command, memory read port and GPIO header signals of
// the gpio_stream_tx output stage. The master modport is the transmitter
// side; the slave modport is whatever commands it, serves memory and acks.
interface gpio_stream_tx_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24,
    parameter int GPIO_W = 36,
    parameter int CNT_W  = 16
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic [ADDR_W-1:0] parallelAddress;
    logic [DATA_W-1:0] q;
    logic [GPIO_W-1:0] gpio_out;
    logic              gpio_ack;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, word_count, q, gpio_ack,
        output parallelAddress, gpio_out, busy, done
    );

    modport slave (
        output start, base_addr, word_count, q, gpio_ack,
        input  parallelAddress, gpio_out, busy, done
    );
endinterface

// File: rtl/gpio_stream_tx.sv
// gpio_stream_tx: reads a block of words from the parallel memory port and
// sends each one over the GPIO header with a four-phase req/ack handshake.
// Header layout: [23:0] data, [24] req, [25] last, [26] parity, [35:27] 0.
// Optional feature macro: GPIO_TX_PARITY_EN drives bit 26 with the XOR of
// the data lines; without it bit 26 is tied low.
module gpio_stream_tx #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 24,
    parameter int GPIO_W      = 36,
    parameter int CNT_W       = 16,
    parameter int MEM_LAT     = 1,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    gpio_stream_tx_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_Q,
        SEND,
        ACK_HI,
        ACK_LO,
        FINISH
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

    state_t                 state;
    logic [ADDR_W-1:0]      addr;
    logic [CNT_W-1:0]       remaining;
    logic [1:0]             lat_cnt;
    logic [DATA_W-1:0]      data;
    logic                   req;
    logic                   last;
    logic                   busy;
    logic                   done;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   parity;
    logic [GPIO_W-1:0]      gpio_word;

    // Bring the receiver's asynchronous ack into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.gpio_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef GPIO_TX_PARITY_EN
    assign parity = ^data;
`else
    assign parity = 1'b0;
`endif

    // Assemble the header from registered fields; unused lines stay low.
    always_comb begin
        gpio_word               = '0;
        gpio_word[DATA_W-1:0]   = data;
        gpio_word[24]           = req;
        gpio_word[25]           = last;
        gpio_word[26]           = parity;
    end

    assign bus.gpio_out        = gpio_word;
    assign bus.parallelAddress = addr;
    assign bus.busy            = busy;
    assign bus.done            = done;

    // Transfer sequencer: fetch a word, wait out the read latency, then run
    // the req/ack handshake; FINISH holds done for one cycle before IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            data      <= '0;
            req       <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy <= 1'b1;
                        if (bus.word_count != '0) begin
                            addr      <= bus.base_addr;
                            remaining <= bus.word_count;
                            state     <= FETCH;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT_Q;
                end
                WAIT_Q: begin
                    if (lat_cnt == 2'd0) begin
                        data  <= bus.q;
                        last  <= (remaining == CNT_W'(1));
                        state <= SEND;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                SEND: begin
                    // An ack still high from the previous word must drop first.
                    if (!ack_s) begin
                        req   <= 1'b1;
                        state <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (ack_s) begin
                        req   <= 1'b0;
                        state <= ACK_LO;
                    end
                end
                ACK_LO: begin
                    if (!ack_s) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= FINISH;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        data  <= '0;
                        last  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_stream_tx.sv
// tb_gpio_stream_tx: directed sequence with randomized bases, counts, memory
// contents and receiver delays, checked against a word-list model of the
// transfer computed from the block's rules.
module tb_gpio_stream_tx;

    logic clk;
    logic rst;

    gpio_stream_tx_if #(.ADDR_W(24), .DATA_W(24), .GPIO_W(36), .CNT_W(16)) bus ();

    gpio_stream_tx #(
        .ADDR_W(24), .DATA_W(24), .GPIO_W(36), .CNT_W(16),
        .MEM_LAT(1), .SYNC_STAGES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory model: one-cycle read latency, content selected by mem_mode.
    int          mem_mode = 0;
    logic [23:0] mem_seed = 24'h0;

    function automatic logic [23:0] mem_word(input logic [23:0] a);
        case (mem_mode)
            0:       return 24'hA5A5A5;
            1:       return a;
            default: return (a * 24'd40503) ^ mem_seed;
        endcase
    endfunction

    always @(posedge clk) bus.q <= mem_word(bus.parallelAddress);

    function automatic logic exp_par(input logic [23:0] d);
`ifdef GPIO_TX_PARITY_EN
        return ^d;
`else
        return (d == d) ? 1'b0 : 1'b0;
`endif
    endfunction

    // Receiver: follows req after hi_dly/lo_dly cycles; can be overridden.
    logic ack_resp = 1'b0;
    logic ack_ovr = 1'b1;
    logic ack_ovr_val = 1'b1;
    int   hi_dly = 3;
    int   lo_dly = 2;
    int   resp_cnt = 0;
    assign bus.gpio_ack = ack_ovr ? ack_ovr_val : ack_resp;

    // Observed words and protocol event counters.
    logic [23:0] mon_addr[$];
    logic [23:0] mon_data[$];
    logic        mon_last[$];
    logic        mon_par[$];
    int          req_rises = 0;
    int          done_cnt = 0;
    int          stale_viol = 0;
    int          stable_viol = 0;
    int          hi_viol = 0;
    logic        prev_req = 1'b0;
    logic [25:0] prev_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.gpio_out[24] && !prev_req) begin
                mon_addr.push_back(bus.parallelAddress);
                mon_data.push_back(bus.gpio_out[23:0]);
                mon_last.push_back(bus.gpio_out[25]);
                mon_par.push_back(bus.gpio_out[26]);
                req_rises++;
                if (bus.gpio_ack) stale_viol++;
            end
            if (bus.gpio_out[24] && prev_req && bus.gpio_out[25:0] != prev_word) stable_viol++;
            if (bus.gpio_out[35:27] != 9'd0) hi_viol++;
            if (bus.done) done_cnt++;
            prev_req  = bus.gpio_out[24];
            prev_word = bus.gpio_out[25:0];
        end
        if (bus.gpio_out[24] != ack_resp) begin
            resp_cnt++;
            if (resp_cnt >= (ack_resp ? lo_dly : hi_dly)) begin
                ack_resp = ~ack_resp;
                resp_cnt = 0;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen on the following rising edge.
    task automatic start_burst(input logic [23:0] base, input logic [15:0] cnt);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = cnt;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.base_addr  = 24'($urandom);
        bus.word_count = 16'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    // Expected transfer: words from base upward (24-bit wrap), last on the final one.
    task automatic compare_burst(input string tag, input logic [23:0] base, input int cnt,
                                 input int idx0, input int rises0, input int done0);
        logic [23:0] a;
        logic [23:0] d;
        check({tag, "_words"}, 64'(mon_data.size() - idx0), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (idx0 + i < mon_data.size()) begin
                a = base + 24'(i);
                d = mem_word(a);
                check($sformatf("%s_addr%0d", tag, i), 64'(mon_addr[idx0+i]), 64'(a));
                check($sformatf("%s_data%0d", tag, i), 64'(mon_data[idx0+i]), 64'(d));
                check($sformatf("%s_last%0d", tag, i), 64'(mon_last[idx0+i]), 64'(i == cnt - 1));
                check($sformatf("%s_par%0d", tag, i), 64'(mon_par[idx0+i]), 64'(exp_par(d)));
            end
        end
        check({tag, "_req_pulses"}, 64'(req_rises - rises0), 64'(cnt));
        check({tag, "_done_pulses"}, 64'(done_cnt - done0), 64'd1);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int          idx0;
        int          rises0;
        int          done0;
        int          cnt;
        int          n;
        logic [23:0] base;

        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        rst            = 1'b1;
        mem_seed       = 24'($urandom);

        // Reset with ack held high
        repeat (2) @(negedge clk);
        check("rst_gpio", 64'(bus.gpio_out), 64'd0);
        check("rst_addr", 64'(bus.parallelAddress), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst     = 1'b0;
        ack_ovr = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_gpio", 64'(bus.gpio_out), 64'd0);
        check("idle_addr", 64'(bus.parallelAddress), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_done", 64'(bus.done), 64'd0);

        // Single word with fixed receiver timing
        mem_mode = 0; hi_dly = 3; lo_dly = 2;
        idx0 = mon_data.size(); rises0 = req_rises; done0 = done_cnt;
        start_burst(24'd179, 16'd1);
        check("sw_busy", 64'(bus.busy), 64'd1);
        check("sw_addr", 64'(bus.parallelAddress), 64'd179);
        @(negedge clk);
        @(negedge clk);
        check("sw_req_before", 64'(bus.gpio_out[24]), 64'd0);
        @(negedge clk);
        check("sw_req_rise", 64'(bus.gpio_out[24]), 64'd1);
        wait_done("sw");
        compare_burst("sw", 24'd179, 1, idx0, rises0, done0);

        // Burst across the top of the address space
        mem_mode = 1; hi_dly = $urandom_range(1, 4); lo_dly = $urandom_range(1, 4);
        idx0 = mon_data.size(); rises0 = req_rises; done0 = done_cnt;
        start_burst(24'hFFFFFE, 16'd4);
        wait_done("wrap");
        compare_burst("wrap", 24'hFFFFFE, 4, idx0, rises0, done0);

        // Random bursts
        mem_mode = 2;
        for (int r = 0; r < 3; r++) begin
            hi_dly = $urandom_range(1, 5); lo_dly = $urandom_range(1, 5);
            base = 24'($urandom);
            cnt  = $urandom_range(1, 6);
            idx0 = mon_data.size(); rises0 = req_rises; done0 = done_cnt;
            start_burst(base, 16'(cnt));
            wait_done($sformatf("rnd%0d", r));
            compare_burst($sformatf("rnd%0d", r), base, cnt, idx0, rises0, done0);
        end

        // Zero count: done pulse only
        rises0 = req_rises;
        start_burst(24'($urandom), 16'd0);
        check("zc_done_e1", 64'(bus.done), 64'd0);
        @(negedge clk);
        check("zc_done_e2", 64'(bus.done), 64'd1);
        @(negedge clk);
        check("zc_done_e3", 64'(bus.done), 64'd0);
        check("zc_busy_e3", 64'(bus.busy), 64'd0);
        repeat (10) @(negedge clk);
        check("zc_no_req", 64'(req_rises - rises0), 64'd0);

        // Start during a burst is ignored
        hi_dly = 2; lo_dly = 3;
        base = 24'($urandom);
        idx0 = mon_data.size(); rises0 = req_rises; done0 = done_cnt;
        start_burst(base, 16'd3);
        repeat (6) @(negedge clk);
        check("ign_busy", 64'(bus.busy), 64'd1);
        start_burst(base + 24'h100, 16'd5);
        wait_done("ign");
        repeat (10) @(negedge clk);
        compare_burst("ign", base, 3, idx0, rises0, done0);

        // Stale ack high at start holds off req
        ack_ovr = 1'b1; ack_ovr_val = 1'b1;
        base = 24'($urandom);
        idx0 = mon_data.size(); rises0 = req_rises; done0 = done_cnt;
        start_burst(base, 16'd2);
        repeat (12) @(negedge clk);
        check("stale_req_held", 64'(bus.gpio_out[24]), 64'd0);
        check("stale_no_rise", 64'(req_rises - rises0), 64'd0);
        ack_ovr = 1'b0;
        wait_done("stale");
        compare_burst("stale", base, 2, idx0, rises0, done0);

        // Reset while waiting for ack high, then a clean transfer
        hi_dly = 4; lo_dly = 2;
        start_burst(24'($urandom), 16'd4);
        n = 0;
        while (bus.gpio_out[24] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_req_seen", 64'(bus.gpio_out[24]), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_gpio", 64'(bus.gpio_out), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_addr", 64'(bus.parallelAddress), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        base = 24'($urandom);
        idx0 = mon_data.size(); rises0 = req_rises; done0 = done_cnt;
        start_burst(base, 16'd3);
        wait_done("after_rst");
        compare_burst("after_rst", base, 3, idx0, rises0, done0);

        // Parity patterns 0x000001, 0x000002, 0x000003
        mem_mode = 1; hi_dly = 1; lo_dly = 1;
        idx0 = mon_data.size(); rises0 = req_rises; done0 = done_cnt;
        start_burst(24'd1, 16'd3);
        wait_done("par");
        compare_burst("par", 24'd1, 3, idx0, rises0, done0);

        // Protocol invariants over the whole run
        check("stale_ack_rises", 64'(stale_viol), 64'd0);
        check("unstable_during_req", 64'(stable_viol), 64'd0);
        check("upper_bits_set", 64'(hi_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
